chunk_serial_adder: RTL and testbench

- Parametrised multi-cycle adder: WIDTH-bit operands, CHUNK bits summed per cycle, carry held in a register between chunks.
- Successor to the single-bit combinational adder cells. Replaces wide combinational carry chains where area and timing matter more than latency.
- Sits between operand producers and consumers. Uses a valid/ready handshake on both sides.

---
 rtl/csa_pkg.sv | 21 ++
 rtl/chunk_adder.sv | 26 ++
 rtl/chunk_serial_adder.sv | 154 +++++++++++++++
 tb/tb_chunk_serial_adder.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared definitions for the chunk-serial adder: FSM states and the
// elaboration-time helpers that size the chunk counter.
package csa_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Number of chunks needed to cover one operand.
    function automatic int calc_nch(input int width, input int chunk);
        return width / chunk;
    endfunction

    // Chunk counter width; never narrower than one bit so NCH==1 still works.
    function automatic int calc_cnt_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder built from full-adder cells.
// Also exposes the carry into its MSB so the parent can derive signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder: sums CHUNK bits per cycle, carrying between chunks in a
// register, with valid/ready handshakes on both sides.
// Optional feature macro: CHUNK_SERIAL_ADDER_OVF_EN enables the signed
// overflow flag; when undefined ovf is tied low.
module chunk_serial_adder
    import csa_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int             NCH      = calc_nch(WIDTH, CHUNK);
    localparam int             CW       = calc_cnt_w(NCH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(NCH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] sum_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic [CW-1:0]    idx_reg;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             co_chunk;
    logic             c_msb;
    logic             accept;
    logic             last_chunk;

    // Only the captured operands feed the adder; live inputs are ignored after acceptance.
    assign a_chunk    = a_reg[idx_reg*CHUNK +: CHUNK];
    assign b_chunk    = b_reg[idx_reg*CHUNK +: CHUNK];
    assign accept     = in_valid && (state_reg == IDLE);
    assign last_chunk = (idx_reg == LAST_IDX);

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_chunk_adder (
        .a     (a_chunk),
        .b     (b_chunk),
        .ci    (carry_reg),
        .s     (s_chunk),
        .co    (co_chunk),
        .c_msb (c_msb)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture and chunk-by-chunk accumulation of the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            idx_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        idx_reg   <= '0;
                    end
                end
                RUN: begin
                    sum_reg[idx_reg*CHUNK +: CHUNK] <= s_chunk;
                    carry_reg                       <= co_chunk;
                    idx_reg                         <= idx_reg + 1'b1;
                    if (last_chunk) begin
                        cout_reg <= co_chunk;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;

`ifdef CHUNK_SERIAL_ADDER_OVF_EN
    logic ovf_reg;

    // Signed overflow is latched alongside cout when the final chunk completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (state_reg == RUN && last_chunk) begin
            ovf_reg <= co_chunk ^ c_msb;
        end
    end

    assign ovf = ovf_reg;
`else
    logic unused_c_msb;

    assign unused_c_msb = c_msb;
    assign ovf          = 1'b0;
`endif

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Self-checking bench for chunk_serial_adder (WIDTH=16, CHUNK=4).
module tb_chunk_serial_adder;

    localparam int WIDTH = 16;
    localparam int CHUNK = 4;
    localparam int NCH   = WIDTH / CHUNK;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             cin = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int vectors     = 0;
    int miscompares = 0;

    chunk_serial_adder #(
        .WIDTH (WIDTH),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic. Returns {ovf, cout, sum}.
    function automatic logic [17:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
        int unsigned u;
        int          s;
        logic        v;
        u = 32'(x) + 32'(y) + 32'(c);
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
`ifdef CHUNK_SERIAL_ADDER_OVF_EN
        v = (s > 32767) || (s < -32768);
`else
        v = 1'b0;
`endif
        return {v, u[16], u[15:0]};
    endfunction

    // One full transaction. early: out_ready high from acceptance.
    // hold: backpressure cycles in HOLD. noise: wiggle inputs with in_valid during RUN.
    task automatic run_txn(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                           input bit early, input int hold, input bit noise);
        logic [17:0] exp;
        int          waited;
        exp    = ref_add(ta, tb, tc);
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready_idle", 32'(in_ready), 32'd1);
        a         = ta;
        b         = tb;
        cin       = tc;
        in_valid  = 1'b1;
        out_ready = early;
        @(negedge clk);
        for (int i = 1; i <= NCH; i++) begin
            if (noise) begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                cin      = 1'($urandom);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            check("in_ready_busy", 32'(in_ready), 32'd0);
            check("out_valid_early", 32'(out_valid), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("out_valid_rise", 32'(out_valid), 32'd1);
        check("sum", 32'(sum), 32'(exp[15:0]));
        check("cout", 32'(cout), 32'(exp[16]));
        check("ovf", 32'(ovf), 32'(exp[17]));
        if (!early) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_ready", 32'(in_ready), 32'd0);
                check("hold_sum", 32'(sum), 32'(exp[15:0]));
                check("hold_cout", 32'(cout), 32'(exp[16]));
            end
            out_ready = 1'b1;
        end
        @(negedge clk);
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;
        $display("txn a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d ovf=%0d (exp %04h %0d %0d)",
                 ta, tb, tc, sum, cout, ovf, exp[15:0], exp[16], exp[17]);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_txn(16'h00FF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_txn(16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_txn(16'hFFFF, 16'h0000, 1'b1, 1'b0, 1, 1'b0);
        run_txn(16'h1234, 16'h0F0F, 1'b1, 1'b0, 10, 1'b0);
        run_txn(16'h0A0A, 16'h5050, 1'b0, 1'b0, 2, 1'b1);

        // Reset during RUN cycle 2 discards the partial result.
        a        = 16'hABCD;
        b        = 16'h1357;
        cin      = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset mid-RUN applied");

        run_txn(16'h1234, 16'h4321, 1'b0, 1'b1, 0, 1'b0);
        run_txn(16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 1'b0);
        run_txn(16'h8000, 16'h8000, 1'b0, 1'b0, 1, 1'b0);

        for (int n = 0; n < 40; n++) begin
            run_txn(16'($urandom), 16'($urandom), 1'($urandom),
                    1'($urandom), int'($urandom_range(3, 0)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
